// File: rtl/bus_pkg.sv
// Shared definitions for the snooping bus: the command word layout, the op codes,
// the idle word and the arbiter FSM encoding.
// Used by the arbiter, the memory and the cache controllers.
package bus_pkg;

    // Word and counter widths
    localparam int unsigned BUS_W  = 11;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 3;
    localparam int unsigned CNT_W  = 8;

    // Field bit positions inside a bus word
    localparam int unsigned FLAG_BIT = 10;
    localparam int unsigned ID_LSB   = 8;
    localparam int unsigned RSV_LSB  = 6;
    localparam int unsigned OP_LSB   = 4;
    localparam int unsigned ADDR_BIT = 3;
    localparam int unsigned DATA_LSB = 0;

    // Op codes
    localparam logic [OP_W-1:0] READ_MISS  = 2'b00;
    localparam logic [OP_W-1:0] WRITE_MISS = 2'b01;
    localparam logic [OP_W-1:0] INVALIDATE = 2'b10;
    localparam logic [OP_W-1:0] EMPTY      = 2'b11;

    // The bus idles on op=empty; all-zeros would be a read miss to address 0
    localparam logic [BUS_W-1:0] EMPTY_WORD = 11'h030;

    typedef struct packed {
        logic              flag;
        logic [ID_W-1:0]   id;
        logic [1:0]        rsv;
        logic [OP_W-1:0]   op;
        logic              addr;
        logic [DATA_W-1:0] data;
    } bus_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Force the requester id into a command word and clear the reserved bits
    function automatic bus_word_t stamp_word(input logic [BUS_W-1:0] raw,
                                             input logic [ID_W-1:0]  id);
        bus_word_t w;
        w     = bus_word_t'(raw);
        w.id  = id;
        w.rsv = 2'b00;
        return w;
    endfunction

    // A memory reply belongs to requester id when it carries op=empty and that id
    function automatic logic is_reply_for(input logic [BUS_W-1:0] resp,
                                          input logic [ID_W-1:0]  id);
        return (resp[OP_LSB +: OP_W] == EMPTY) && (resp[ID_LSB +: ID_W] == id);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin choice among pending requesters.
//   reqValid  : pending request per processor
//   lastGrant : id of the previous winner; search starts at lastGrant+1
//   winner    : one-hot winner (all zero when nobody requests)
//   anyValid  : at least one request pending
module rr_picker
    import bus_pkg::*;
#(
    parameter int unsigned N_PROC = 4
) (
    input  logic [N_PROC-1:0] reqValid,
    input  logic [ID_W-1:0]   lastGrant,
    output logic [N_PROC-1:0] winner,
    output logic              anyValid
);

    localparam int unsigned IDX_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

    logic found;

    // Walk the requesters in rotation order, the first one pending wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= int'(N_PROC); k++) begin
            if (!found && reqValid[IDX_W'((int'(lastGrant) + k) % int'(N_PROC))]) begin
                winner[IDX_W'((int'(lastGrant) + k) % int'(N_PROC))] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign anyValid = |reqValid;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin snooping-bus arbiter in front of the shared memory.
//   clock, reset   : posedge clock, synchronous active-high reset
//   reqValid       : per-processor request pending
//   reqBus         : per-processor command words, processor i at [11i+10:11i]
//   grant          : one-hot, one-cycle pulse when a request is accepted
//   barramentoOut  : command word to memory and snoopers (EMPTY_WORD when idle)
//   memResp        : memory reply word
//   respValid      : one-cycle pulse, respWord holds the reply
//   respWord       : reply broadcast to all processors
//   timeoutErr     : one-cycle pulse when a read miss gets no reply
//   busy           : arbiter is not idle
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned N_PROC  = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_PROC-1:0]       reqValid,
    input  logic [BUS_W*N_PROC-1:0] reqBus,
    output logic [N_PROC-1:0]       grant,
    output logic [BUS_W-1:0]        barramentoOut,
    input  logic [BUS_W-1:0]        memResp,
    output logic                    respValid,
    output logic [BUS_W-1:0]        respWord,
    output logic                    timeoutErr,
    output logic                    busy
);

    arb_state_t       state;
    logic [ID_W-1:0]  last_grant;
    bus_word_t        latched;
    logic [CNT_W-1:0] wait_cnt;

    logic [N_PROC-1:0] pick_onehot;
    logic              pick_any;
    logic [ID_W-1:0]   win_id;
    logic [BUS_W-1:0]  win_raw;
    bus_word_t         win_cmd;
    logic              reply_match;

    rr_picker #(
        .N_PROC (N_PROC)
    ) u_picker (
        .reqValid  (reqValid),
        .lastGrant (last_grant),
        .winner    (pick_onehot),
        .anyValid  (pick_any)
    );

    // Encode the winner and pull its command word off the request bus
    always_comb begin
        win_id  = '0;
        win_raw = EMPTY_WORD;
        for (int i = 0; i < int'(N_PROC); i++) begin
            if (pick_onehot[i]) begin
                win_id  = ID_W'(i);
                win_raw = reqBus[i*BUS_W +: BUS_W];
            end
        end
    end

    assign win_cmd     = stamp_word(win_raw, win_id);
    assign reply_match = is_reply_for(memResp, latched.id);

    // Arbiter FSM; every output is registered and pulses default low each cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            last_grant    <= ID_W'(N_PROC - 1);
            latched       <= bus_word_t'(EMPTY_WORD);
            wait_cnt      <= '0;
            grant         <= '0;
            barramentoOut <= EMPTY_WORD;
            respValid     <= 1'b0;
            respWord      <= '0;
            timeoutErr    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            grant         <= '0;
            respValid     <= 1'b0;
            timeoutErr    <= 1'b0;
            barramentoOut <= EMPTY_WORD;

            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (pick_any) begin
                        grant      <= pick_onehot;
                        last_grant <= win_id;
                        latched    <= win_cmd;
                        // An empty op is acknowledged but never reaches the bus
                        if (win_cmd.op != EMPTY) begin
                            state         <= ST_ISSUE;
                            barramentoOut <= win_cmd;
                            busy          <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (latched.op == READ_MISS) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    // A reply on the last counted cycle still wins over the timeout
                    if (reply_match) begin
                        respWord  <= memResp;
                        respValid <= 1'b1;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeoutErr <= 1'b1;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: timeline model of the arbiter plus directed scenarios.
module tb_bus_arbiter;

    localparam int N   = 4;
    localparam int TO  = 8;
    localparam int BW  = 11;
    localparam logic [BW-1:0] IDLE_BUS  = 11'h030;
    localparam logic [BW-1:0] IDLE_RESP = 11'h000;

    logic            clock;
    logic            reset;
    logic [N-1:0]    reqValid;
    logic [BW*N-1:0] reqBus;
    logic [N-1:0]    grant;
    logic [BW-1:0]   barramentoOut;
    logic [BW-1:0]   memResp;
    logic            respValid;
    logic [BW-1:0]   respWord;
    logic            timeoutErr;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(.N_PROC(N), .TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqBus        (reqBus),
        .grant         (grant),
        .barramentoOut (barramentoOut),
        .memResp       (memResp),
        .respValid     (respValid),
        .respWord      (respWord),
        .timeoutErr    (timeoutErr),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic flag, input logic [1:0] id,
                                         input logic [1:0] op, input logic addr,
                                         input logic [2:0] data);
        return {flag, id, 2'b00, op, addr, data};
    endfunction

    // Memory: answers a read miss seen on the bus one cycle later, if enabled
    logic [3:0]    mem [2];
    logic          mem_on;
    logic          ovr_on;
    logic [BW-1:0] ovr_word;
    logic [BW-1:0] pend_word;

    always @(negedge clock) begin
        if (mem_on && barramentoOut[5:4] == 2'b00)
            pend_word = {mem[barramentoOut[3]][3], barramentoOut[9:8], 2'b00, 2'b11,
                         barramentoOut[3], mem[barramentoOut[3]][2:0]};
        else
            pend_word = IDLE_RESP;
    end

    always @(posedge clock) begin
        #1;
        memResp = ovr_on ? ovr_word : pend_word;
    end

    // Timeline model: tracks when the arbiter is next free to arbitrate and
    // which window of edges may accept a reply for the outstanding read miss
    int            t = 0;
    int            next_free = 0;
    int            m_last = N - 1;
    bit            waiting = 0;
    int            win_lo, win_hi;
    logic [1:0]    wait_id;
    bit            chk_en = 0;
    logic [N-1:0]  e_grant;
    logic [BW-1:0] e_bus;
    logic          e_rv, e_to, e_busy;
    logic [BW-1:0] e_rword = '0;

    always @(posedge clock) begin
        logic [BW-1:0] w;
        int win;
        e_grant = '0;
        e_bus   = IDLE_BUS;
        e_rv    = 1'b0;
        e_to    = 1'b0;
        if (reset) begin
            chk_en    = 1;
            next_free = t + 1;
            m_last    = N - 1;
            waiting   = 0;
            e_rword   = '0;
        end else if (waiting) begin
            if (t >= win_lo && memResp[5:4] == 2'b11 && memResp[9:8] == wait_id) begin
                e_rv      = 1'b1;
                e_rword   = memResp;
                waiting   = 0;
                next_free = t + 1;
            end else if (t == win_hi) begin
                e_to      = 1'b1;
                waiting   = 0;
                next_free = t + 1;
            end
        end else if (t >= next_free) begin
            next_free = t + 1;
            if (reqValid != '0) begin
                win = -1;
                for (int k = 1; k <= N; k++)
                    if (win < 0 && reqValid[(m_last + k) % N]) win = (m_last + k) % N;
                w = reqBus[win*BW +: BW];
                w = {w[10], 2'(win), 2'b00, w[5:0]};
                e_grant[win] = 1'b1;
                m_last = win;
                if (w[5:4] != 2'b11) begin
                    e_bus     = w;
                    next_free = t + 2;
                    if (w[5:4] == 2'b00) begin
                        waiting = 1;
                        wait_id = w[9:8];
                        win_lo  = t + 2;
                        win_hi  = t + 1 + TO;
                    end
                end
            end
        end
        e_busy = waiting || (next_free > t + 1);
        t++;
        #1;
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(e_grant));
            chk("barramentoOut", 32'(barramentoOut), 32'(e_bus));
            chk("respValid", 32'(respValid), 32'(e_rv));
            chk("respWord", 32'(respWord), 32'(e_rword));
            chk("timeoutErr", 32'(timeoutErr), 32'(e_to));
            chk("busy", 32'(busy), 32'(e_busy));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen [$];
        int when [$];
        int k;

        reset = 1'b1; reqValid = '0; reqBus = '0;
        mem_on = 1'b0; ovr_on = 1'b0; ovr_word = IDLE_RESP;
        mem[0] = 4'b0101; mem[1] = 4'b1000;
        memResp = IDLE_RESP; pend_word = IDLE_RESP;
        tick(2);
        chk("rst_bus", 32'(barramentoOut), 32'h030);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_respword", 32'(respWord), 0);
        reset = 1'b0;
        tick(1);

        // P2 read miss to address 1, memory answers
        mem_on = 1'b1;
        reqBus[2*BW +: BW] = mk(1'b0, 2'd0, 2'b00, 1'b1, 3'd0);
        reqValid = 4'b0100;
        tick(1);
        reqValid = '0;
        chk("rm_grant", 32'(grant), 32'b0100);
        chk("rm_bus_id", 32'(barramentoOut[9:8]), 2);
        chk("rm_bus_op", 32'(barramentoOut[5:4]), 0);
        chk("rm_bus_addr", 32'(barramentoOut[3]), 1);
        tick(1);
        chk("rm_bus_idle", 32'(barramentoOut), 32'h030);
        chk("rm_grant_low", 32'(grant), 0);
        tick(1);
        chk("rm_respvalid", 32'(respValid), 1);
        chk("rm_resp_id", 32'(respWord[9:8]), 2);
        chk("rm_resp_op", 32'(respWord[5:4]), 3);
        chk("rm_resp_data", 32'(respWord[2:0]), 0);
        tick(2);

        // All four requesters issue write misses continuously
        do_reset();
        for (int i = 0; i < N; i++) reqBus[i*BW +: BW] = mk(1'b0, 2'(i), 2'b01, 1'b0, 3'(i));
        reqValid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (grant != '0) begin seen.push_back(int'(grant)); when.push_back(c); end
            chk("wm_no_resp", 32'(respValid), 0);
        end
        reqValid = '0;
        chk("wm_count", 32'(seen.size()), 5);
        if (seen.size() >= 5) begin
            chk("wm_g0", 32'(seen[0]), 1);
            chk("wm_g1", 32'(seen[1]), 2);
            chk("wm_g2", 32'(seen[2]), 4);
            chk("wm_g3", 32'(seen[3]), 8);
            chk("wm_g4", 32'(seen[4]), 1);
            for (int i = 1; i < 5; i++) chk("wm_spacing", 32'(when[i] - when[i-1]), 2);
        end
        tick(3);

        // P1 invalidate carrying a wrong id
        reqBus[1*BW +: BW] = mk(1'b1, 2'd3, 2'b10, 1'b1, 3'd5);
        reqValid = 4'b0010;
        tick(1);
        reqValid = '0;
        chk("inv_grant", 32'(grant), 32'b0010);
        chk("inv_bus", 32'(barramentoOut), 32'(mk(1'b1, 2'd1, 2'b10, 1'b1, 3'd5)));
        chk("inv_busy", 32'(busy), 1);
        tick(1);
        chk("inv_busy_low", 32'(busy), 0);
        chk("inv_bus_idle", 32'(barramentoOut), 32'h030);
        tick(2);

        // Silent memory: read miss times out, then a stray reply is ignored
        mem_on = 1'b0;
        reqBus[0 +: BW] = mk(1'b0, 2'd0, 2'b00, 1'b0, 3'd0);
        reqValid = 4'b0001;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (c == 1) reqValid = '0;
            if (timeoutErr && k == 0) k = c;
        end
        chk("to_cycle", 32'(k), 10);
        chk("to_busy", 32'(busy), 0);
        ovr_word = mk(1'b0, 2'd0, 2'b11, 1'b0, 3'd7);
        ovr_on = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("to_late_reply", 32'(respValid), 0);
        end
        ovr_on = 1'b0;
        tick(2);

        // Reset while waiting; the reply lands on the reset edge and is dropped
        reqBus[3*BW +: BW] = mk(1'b0, 2'd0, 2'b00, 1'b1, 3'd0);
        reqValid = 4'b1000;
        tick(1);
        reqValid = '0;
        tick(2);
        chk("mw_busy", 32'(busy), 1);
        ovr_word = mk(1'b0, 2'd3, 2'b11, 1'b1, 3'd2);
        ovr_on = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mw_rst_busy", 32'(busy), 0);
        chk("mw_rst_rv", 32'(respValid), 0);
        chk("mw_rst_bus", 32'(barramentoOut), 32'h030);
        for (int c = 0; c < 2; c++) begin
            tick(1);
            chk("mw_no_rv", 32'(respValid), 0);
        end
        ovr_on = 1'b0;
        tick(1);

        // Empty op: grant only, nothing on the bus
        reqBus[0 +: BW] = mk(1'b0, 2'd0, 2'b11, 1'b0, 3'd0);
        reqValid = 4'b0001;
        tick(1);
        reqValid = '0;
        chk("emp_grant", 32'(grant), 32'b0001);
        chk("emp_bus", 32'(barramentoOut), 32'h030);
        chk("emp_busy", 32'(busy), 0);
        tick(1);
        chk("emp_grant_low", 32'(grant), 0);
        chk("emp_busy_low", 32'(busy), 0);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
